// File: rtl/ioctl_sdram_loader_pkg.sv
// Shared types for the ioctl -> SDRAM ROM loader.
//   state_e      : issue FSM states
//   entry_t      : one buffered word (word address + big-endian data)
//   PAD_BYTE_DEF : default fill byte for unpaired halves of a word
package ioctl_sdram_loader_pkg;

    // Widest word address an entry can carry (ioctl_addr is 25 bits wide).
    localparam int         ADDR_MAX_W   = 24;
    localparam logic [7:0] PAD_BYTE_DEF = 8'hFF;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic [ADDR_MAX_W-1:0] waddr;
        logic [15:0]           data;
    } entry_t;

endpackage

// File: rtl/ioctl_sdram_loader_fifo.sv
// loader_fifo: synchronous show-ahead FIFO.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   push_i, push_data_i   : write request (ignored while full)
//   pop_i, pop_data_o     : read request (ignored while empty); pop_data_o shows the head
//   full_o, empty_o       : occupancy flags
//   count_o               : number of stored entries
module loader_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         pop_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o     = (count_q == (AW+1)'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries data only; validity is tracked by the pointers.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/ioctl_sdram_loader.sv
// ioctl_sdram_loader: packs the data_io ROM download byte stream into
// big-endian 16-bit words, buffers them and writes them to the SDRAM
// controller's ROM-load port with a toggle req/ack handshake.
//   clk_sys, reset          : clock, synchronous active-high reset
//   rom_download            : download window
//   ioctl_wr/addr/dout      : byte strobe, byte address, byte data
//   sdram_addr/data/req     : current word request; req toggles per write
//   sdram_ack               : controller copy of req once the write is done
//   busy/done/overrun       : status (done and overrun are sticky)
module ioctl_sdram_loader
    import ioctl_sdram_loader_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter int         WADDR_W    = 24,
    parameter logic [7:0] PAD_BYTE   = PAD_BYTE_DEF
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic               rom_download,
    input  logic               ioctl_wr,
    input  logic [24:0]        ioctl_addr,
    input  logic [7:0]         ioctl_dout,
    output logic [WADDR_W-1:0] sdram_addr,
    output logic [15:0]        sdram_data,
    output logic               sdram_req,
    input  logic               sdram_ack,
    output logic               busy,
    output logic               done,
    output logic               overrun
);

    // Packer state
    logic               pend_q, pend_d;
    logic [7:0]         hi_q, hi_d;
    logic [WADDR_W-1:0] waddr_q, waddr_d;
    logic               defer_vld_q, defer_vld_d;
    entry_t             defer_q, defer_d;
    logic               dl_q, end_seen_q, done_q, overrun_q;

    // Issue FSM state
    state_e             state_q;
    logic               req_q;
    logic [WADDR_W-1:0] addr_q;
    logic [15:0]        data_q;

    logic               push;
    entry_t             push_ent;
    entry_t             head;
    logic               fifo_full, fifo_empty, issue;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic [WADDR_W-1:0] wa_in;
    logic               dl_rise, dl_fall;

    assign wa_in   = ioctl_addr[WADDR_W:1];
    assign dl_rise = rom_download && !dl_q;
    assign dl_fall = !rom_download && dl_q;

    function automatic entry_t mk_entry(input logic [WADDR_W-1:0] wa, input logic [15:0] d);
        entry_t e;
        e.waddr = ADDR_MAX_W'(wa);
        e.data  = d;
        return e;
    endfunction

    // Packer: at most one FIFO push per cycle. The only double-push case
    // (stale even byte plus unmatched odd byte) defers the odd word by one
    // cycle; the strobe spacing guarantees that slot is free.
    always_comb begin
        pend_d      = pend_q;
        hi_d        = hi_q;
        waddr_d     = waddr_q;
        defer_vld_d = 1'b0;
        defer_d     = defer_q;
        push        = 1'b0;
        push_ent    = '0;
        if (defer_vld_q) begin
            push     = 1'b1;
            push_ent = defer_q;
        end
        if (dl_fall) begin
            if (pend_q) begin
                push     = 1'b1;
                push_ent = mk_entry(waddr_q, {hi_q, PAD_BYTE});
                pend_d   = 1'b0;
            end
        end else if (ioctl_wr && rom_download) begin
            if (!ioctl_addr[0]) begin
                if (pend_q) begin
                    push     = 1'b1;
                    push_ent = mk_entry(waddr_q, {hi_q, PAD_BYTE});
                end
                hi_d    = ioctl_dout;
                waddr_d = wa_in;
                pend_d  = 1'b1;
            end else if (pend_q && (waddr_q == wa_in)) begin
                push     = 1'b1;
                push_ent = mk_entry(wa_in, {hi_q, ioctl_dout});
                pend_d   = 1'b0;
            end else if (pend_q) begin
                push        = 1'b1;
                push_ent    = mk_entry(waddr_q, {hi_q, PAD_BYTE});
                defer_vld_d = 1'b1;
                defer_d     = mk_entry(wa_in, {PAD_BYTE, ioctl_dout});
                pend_d      = 1'b0;
            end else begin
                push     = 1'b1;
                push_ent = mk_entry(wa_in, {PAD_BYTE, ioctl_dout});
            end
        end
    end

    loader_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(entry_t))
    ) u_fifo (
        .clk_i       (clk_sys),
        .rst_i       (reset),
        .push_i      (push && !fifo_full),
        .push_data_i (push_ent),
        .pop_i       (issue),
        .pop_data_o  (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign busy  = pend_q || defer_vld_q || (fifo_count != '0) || (state_q == WAIT);
    assign issue = (state_q == IDLE) && !fifo_empty && (req_q == sdram_ack);

    // Packer registers and sticky status
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            pend_q      <= 1'b0;
            defer_vld_q <= 1'b0;
            dl_q        <= 1'b0;
            end_seen_q  <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            defer_vld_q <= defer_vld_d;
            dl_q        <= rom_download;
            if (push && fifo_full) overrun_q <= 1'b1;
            if (dl_rise) begin
                end_seen_q <= 1'b0;
                done_q     <= 1'b0;
            end else begin
                if (dl_fall) end_seen_q <= 1'b1;
                if (end_seen_q && !busy) done_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        hi_q    <= hi_d;
        waddr_q <= waddr_d;
        defer_q <= defer_d;
    end

    // Issue FSM: pop and toggle req in one edge, then hold until ack matches.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (issue) begin
                    addr_q  <= head.waddr[WADDR_W-1:0];
                    data_q  <= head.data;
                    req_q   <= ~req_q;
                    state_q <= WAIT;
                end
                WAIT: if (req_q == sdram_ack) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sdram_addr = addr_q;
    assign sdram_data = data_q;
    assign sdram_req  = req_q;
    assign done       = done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_ioctl_sdram_loader.sv
module tb_ioctl_sdram_loader;

    localparam int FIFO_DEPTH = 4;
    localparam int WADDR_W    = 24;

    logic               clk_sys = 1'b0;
    logic               reset;
    logic               rom_download;
    logic               ioctl_wr;
    logic [24:0]        ioctl_addr;
    logic [7:0]         ioctl_dout;
    logic [WADDR_W-1:0] sdram_addr;
    logic [15:0]        sdram_data;
    logic               sdram_req;
    logic               sdram_ack;
    logic               busy, done, overrun;

    ioctl_sdram_loader #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WADDR_W    (WADDR_W),
        .PAD_BYTE   (8'hFF)
    ) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .rom_download (rom_download),
        .ioctl_wr     (ioctl_wr),
        .ioctl_addr   (ioctl_addr),
        .ioctl_dout   (ioctl_dout),
        .sdram_addr   (sdram_addr),
        .sdram_data   (sdram_data),
        .sdram_req    (sdram_req),
        .sdram_ack    (sdram_ack),
        .busy         (busy),
        .done         (done),
        .overrun      (overrun)
    );

    always #5 clk_sys = ~clk_sys;

    int n_tests = 0;
    int n_fail  = 0;
    int n_req   = 0;

    typedef struct {
        logic [WADDR_W-1:0] a;
        logic [15:0]        d;
    } wr_t;
    wr_t exp_q[$];

    // Reference model: byte-pairing rules at word level
    bit                 m_pend;
    logic [7:0]         m_hi;
    logic [WADDR_W-1:0] m_wa;
    int                 m_limit;   // words the DUT can still accept; -1 = unlimited

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic exp_word(input logic [WADDR_W-1:0] a, input logic [15:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        if (m_limit != 0) exp_q.push_back(w);
        if (m_limit > 0) m_limit--;
    endtask

    task automatic model_byte(input logic [24:0] addr, input logic [7:0] d);
        logic [WADDR_W-1:0] wa;
        wa = addr[WADDR_W:1];
        if (addr[0] == 1'b0) begin
            if (m_pend) exp_word(m_wa, {m_hi, 8'hFF});
            m_pend = 1'b1;
            m_hi   = d;
            m_wa   = wa;
        end else if (m_pend && m_wa == wa) begin
            exp_word(wa, {m_hi, d});
            m_pend = 1'b0;
        end else begin
            if (m_pend) exp_word(m_wa, {m_hi, 8'hFF});
            m_pend = 1'b0;
            exp_word(wa, {8'hFF, d});
        end
    endtask

    // SDRAM controller stand-in: copies req after ack_delay cycles unless held.
    int ack_delay = 3;
    bit ack_hold  = 1'b0;
    int ack_cnt;
    always @(posedge clk_sys) begin
        if (reset) begin
            sdram_ack <= 1'b0;
            ack_cnt   <= 0;
        end else if (sdram_req != sdram_ack && !ack_hold) begin
            if (ack_cnt >= ack_delay - 1) begin
                sdram_ack <= sdram_req;
                ack_cnt   <= 0;
            end else begin
                ack_cnt <= ack_cnt + 1;
            end
        end else begin
            ack_cnt <= 0;
        end
    end

    // Monitor: every req toggle is one write, checked against the scoreboard.
    logic last_req = 1'b0;
    always @(negedge clk_sys) begin
        if (reset) begin
            last_req = 1'b0;
        end else if (sdram_req !== last_req) begin
            last_req = sdram_req;
            n_req++;
            if (exp_q.size() == 0) begin
                chk("unexpected_req", 32'(sdram_addr), 32'hFFFF_FFFF);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                chk("wr_addr", 32'(sdram_addr), 32'(w.a));
                chk("wr_data", 32'(sdram_data), 32'(w.d));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        rom_download = 1'b0;
        ioctl_wr     = 1'b0;
        ack_hold     = 1'b0;
        cyc(2);
        reset   = 1'b0;
        m_pend  = 1'b0;
        m_limit = -1;
        exp_q.delete();
        cyc(1);
    endtask

    task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input int gap);
        model_byte(a, d);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        cyc(1);
        ioctl_wr = 1'b0;
        cyc(gap - 1);
    endtask

    task automatic start_dl();
        rom_download = 1'b1;
        cyc(1);
    endtask

    task automatic end_dl();
        if (m_pend) exp_word(m_wa, {m_hi, 8'hFF});
        m_pend       = 1'b0;
        rom_download = 1'b0;
        cyc(1);
    endtask

    task automatic wait_done(input string name, input int budget);
        for (int i = 0; i < budget && done !== 1'b1; i++) cyc(1);
        chk(name, 32'(done), 32'd1);
        chk({name, "_busy"}, 32'(busy), 32'd0);
        chk({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int r0;
        logic [24:0] a;
        reset = 1'b1; rom_download = 1'b0; ioctl_wr = 1'b0;
        ioctl_addr = '0; ioctl_dout = '0;
        m_pend = 1'b0; m_hi = '0; m_wa = '0; m_limit = -1;

        do_reset();
        chk("rst_req",     32'(sdram_req),  32'd0);
        chk("rst_addr",    32'(sdram_addr), 32'd0);
        chk("rst_data",    32'(sdram_data), 32'd0);
        chk("rst_busy",    32'(busy),       32'd0);
        chk("rst_done",    32'(done),       32'd0);
        chk("rst_overrun", 32'(overrun),    32'd0);

        // Pair write
        r0 = n_req;
        start_dl();
        send_byte(25'd0, 8'h12, 2);
        send_byte(25'd1, 8'h34, 2);
        end_dl();
        wait_done("pair_done", 100);
        chk("pair_nreq", 32'(n_req - r0), 32'd1);

        // Trailing odd byte
        do_reset();
        r0 = n_req;
        start_dl();
        send_byte(25'd0, 8'hAA, 2);
        send_byte(25'd1, 8'hBB, 2);
        send_byte(25'd2, 8'hCC, 2);
        end_dl();
        wait_done("odd_done", 100);
        chk("odd_nreq", 32'(n_req - r0), 32'd2);

        // Stalled ack: 1 in flight + FIFO_DEPTH buffered, the 6th word dropped
        do_reset();
        r0 = n_req;
        ack_hold = 1'b1;
        m_limit  = 1 + FIFO_DEPTH;
        start_dl();
        for (int i = 0; i < 12; i++) send_byte(25'(i), 8'($urandom), 2);
        cyc(4);
        chk("stall_overrun", 32'(overrun), 32'd1);
        chk("stall_inflight", 32'(n_req - r0), 32'd1);
        ack_hold = 1'b0;
        end_dl();
        wait_done("stall_done", 200);
        chk("stall_nreq", 32'(n_req - r0), 32'd5);
        chk("stall_overrun_sticky", 32'(overrun), 32'd1);

        // Address jump
        do_reset();
        r0 = n_req;
        start_dl();
        send_byte(25'd0, 8'h11, 2);
        send_byte(25'd8, 8'h22, 2);
        cyc(10);
        chk("jump_first", 32'(n_req - r0), 32'd1);
        send_byte(25'd9, 8'h33, 2);
        end_dl();
        wait_done("jump_done", 100);
        chk("jump_nreq", 32'(n_req - r0), 32'd2);

        // Restart after done: done clears on the rise, data lands from address 0
        r0 = n_req;
        start_dl();
        chk("restart_done_clr", 32'(done), 32'd0);
        send_byte(25'd0, 8'h77, 2);
        send_byte(25'd1, 8'h88, 2);
        end_dl();
        wait_done("restart_done", 100);
        chk("restart_nreq", 32'(n_req - r0), 32'd1);

        // Reset while a request is in flight
        do_reset();
        r0 = n_req;
        ack_hold = 1'b1;
        start_dl();
        send_byte(25'd0, 8'h55, 2);
        send_byte(25'd1, 8'h66, 2);
        for (int i = 0; i < 20 && (n_req - r0) < 1; i++) cyc(1);
        chk("midwait_issued", 32'(n_req - r0), 32'd1);
        do_reset();
        chk("midwait_req",     32'(sdram_req),  32'd0);
        chk("midwait_addr",    32'(sdram_addr), 32'd0);
        chk("midwait_data",    32'(sdram_data), 32'd0);
        chk("midwait_busy",    32'(busy),       32'd0);
        chk("midwait_done",    32'(done),       32'd0);
        chk("midwait_overrun", 32'(overrun),    32'd0);
        cyc(20);
        chk("midwait_quiet", 32'(n_req - r0), 32'd1);

        // Randomized download: mostly sequential bytes with occasional jumps
        for (int t = 0; t < 3; t++) begin
            do_reset();
            ack_delay = $urandom_range(1, 3);
            start_dl();
            a = 25'($urandom_range(0, 15));
            for (int i = 0; i < 40; i++) begin
                if ($urandom_range(0, 9) < 2) a = 25'($urandom);
                send_byte(a, 8'($urandom), $urandom_range(8, 12));
                a = a + 25'd1;
            end
            end_dl();
            wait_done("rand_done", 400);
            chk("rand_overrun", 32'(overrun), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
